// File: rtl/counter_handshake_sampler.sv
// Four-phase requester/consumer for the dual-rail counter: synchronises ack and
// rails, checks codeword and spacer, and emits a binary count with a valid pulse.
module counter_handshake_sampler #(
    parameter int unsigned WIDTH         = 2,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned GAP_CYCLES    = 5,
    parameter int unsigned TIMEOUT       = 255
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_run,
    input  logic             i_clr_err,
    input  logic             i_ack,
    input  logic [WIDTH-1:0] i_rail_t,
    input  logic [WIDTH-1:0] i_rail_f,
    output logic             o_req,
    output logic [WIDTH-1:0] o_count_out,
    output logic             o_count_valid,
    output logic             o_busy,
    output logic             o_code_err,
    output logic             o_seq_err,
    output logic             o_timeout_err
);

    // Timer also paces SETTLE and GAP, so it must be wide enough for all three.
    localparam int unsigned TMO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
    localparam int unsigned TW_A   = (TMO_W > GAP_W) ? TMO_W : GAP_W;
    localparam int unsigned TW_B   = (TW_A > SET_W) ? TW_A : SET_W;
    localparam int unsigned TW     = (TW_B > 0) ? TW_B : 1;
    localparam int unsigned SETTLE_LAST = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;
    localparam int unsigned GAP_LAST    = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_REQ_HI = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_SAMPLE = 3'd3;
    localparam logic [2:0] S_RTZ    = 3'd4;
    localparam logic [2:0] S_GAP    = 3'd5;

    logic [SYNC_STAGES-1:0]            r_ack_sync;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_t_sync;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] r_f_sync;

    logic [2:0]       r_state;
    logic [TW-1:0]    r_timer;
    logic             r_have_prev;
    logic [2:0]       w_state_nxt;
    logic [TW-1:0]    w_timer_nxt;
    logic             w_ack_s;
    logic [WIDTH-1:0] w_t_s;
    logic [WIDTH-1:0] w_f_s;
    logic             w_code_ok;
    logic             w_timeout_hit;
    logic [WIDTH-1:0] w_count_inc;
    logic             w_req_nxt;
    logic             w_load;
    logic             w_code_set;
    logic             w_seq_set;
    logic             w_tmo_set;

    // Input synchronisers; only the final stage is used downstream.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_ack_sync <= '0;
            r_t_sync   <= '0;
            r_f_sync   <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], i_ack};
            r_t_sync   <= {r_t_sync[SYNC_STAGES-2:0], i_rail_t};
            r_f_sync   <= {r_f_sync[SYNC_STAGES-2:0], i_rail_f};
        end
    end

    assign w_ack_s       = r_ack_sync[SYNC_STAGES-1];
    assign w_t_s         = r_t_sync[SYNC_STAGES-1];
    assign w_f_s         = r_f_sync[SYNC_STAGES-1];
    assign w_code_ok     = &(w_t_s ^ w_f_s);
    assign w_count_inc   = o_count_out + WIDTH'(1);
    assign w_timeout_hit = (TIMEOUT != 0) && (r_timer == TW'(TIMEOUT));

    // Next-state and error-set decode.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_code_set  = 1'b0;
        w_seq_set   = 1'b0;
        w_tmo_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_run) w_state_nxt = S_REQ_HI;
            end
            S_REQ_HI: begin
                if (w_ack_s) begin
                    w_state_nxt = S_SETTLE;
                end else if (w_timeout_hit) begin
                    w_tmo_set   = 1'b1;
                    w_state_nxt = S_RTZ;
                end
            end
            S_SETTLE: begin
                if (r_timer == TW'(SETTLE_LAST)) w_state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (w_code_ok) begin
                    w_load    = 1'b1;
                    w_seq_set = r_have_prev && (w_t_s != w_count_inc);
                end else begin
                    w_code_set = 1'b1;
                end
                w_state_nxt = S_RTZ;
            end
            S_RTZ: begin
                // Spacer is judged once the counter has returned ack to zero.
                if (!w_ack_s) begin
                    w_code_set  = (|w_t_s) || (|w_f_s);
                    w_state_nxt = S_GAP;
                end else if (w_timeout_hit) begin
                    w_tmo_set   = 1'b1;
                    w_state_nxt = S_GAP;
                end
            end
            S_GAP: begin
                if (r_timer == TW'(GAP_LAST)) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase

        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end else if (&r_timer) begin
            w_timer_nxt = r_timer;
        end else begin
            w_timer_nxt = r_timer + TW'(1);
        end

        w_req_nxt = (w_state_nxt == S_REQ_HI) || (w_state_nxt == S_SETTLE) ||
                    (w_state_nxt == S_SAMPLE);
    end

    // State, timer and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_timer       <= '0;
            r_have_prev   <= 1'b0;
            o_req         <= 1'b0;
            o_busy        <= 1'b0;
            o_count_out   <= '0;
            o_count_valid <= 1'b0;
            o_code_err    <= 1'b0;
            o_seq_err     <= 1'b0;
            o_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_timer       <= w_timer_nxt;
            o_req         <= w_req_nxt;
            o_busy        <= (w_state_nxt != S_IDLE);
            o_count_valid <= w_load;
            if (w_load) begin
                o_count_out <= w_t_s;
                r_have_prev <= 1'b1;
            end
            o_code_err    <= (o_code_err & ~i_clr_err) | w_code_set;
            o_seq_err     <= (o_seq_err & ~i_clr_err) | w_seq_set;
            o_timeout_err <= (o_timeout_err & ~i_clr_err) | w_tmo_set;
        end
    end

endmodule

// File: tb/tb_counter_handshake_sampler.sv
// Directed bench: a behavioural dual-rail counter answers req, and a vector
// table plus hand sequences cover timeout, spacer and mid-handshake reset.
module tb_counter_handshake_sampler;

    typedef struct {
        logic [1:0] t;
        logic [1:0] f;
        logic       bad_sp;
        logic       clr;
        int         exp_valid;
        logic [1:0] exp_cnt;
        logic       exp_code;
        logic       exp_seq;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       run;
    logic       clr_err;
    logic       ack;
    logic [1:0] rail_t;
    logic [1:0] rail_f;
    logic       req;
    logic [1:0] count_out;
    logic       count_valid;
    logic       busy;
    logic       code_err;
    logic       seq_err;
    logic       timeout_err;

    int checks   = 0;
    int failures = 0;
    int n_valid  = 0;

    // Counter model controls
    logic       m_mute = 1'b0;
    logic       m_bad  = 1'b0;
    logic [1:0] m_t    = 2'b00;
    logic [1:0] m_f    = 2'b00;

    counter_handshake_sampler #(
        .WIDTH(2), .SYNC_STAGES(2), .SETTLE_CYCLES(1), .GAP_CYCLES(5), .TIMEOUT(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .i_clr_err(clr_err),
        .i_ack(ack), .i_rail_t(rail_t), .i_rail_f(rail_f),
        .o_req(req), .o_count_out(count_out), .o_count_valid(count_valid),
        .o_busy(busy), .o_code_err(code_err), .o_seq_err(seq_err),
        .o_timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (count_valid === 1'b1) n_valid++;

    // Behavioural counter_imp: ack three cycles after req, spacer on req fall.
    initial begin
        int dly;
        dly = 0;
        ack = 1'b0; rail_t = 2'b00; rail_f = 2'b00;
        forever begin
            @(negedge clk);
            if (m_mute) begin
                dly = 0;
            end else if (req && !ack) begin
                if (dly == 2) begin
                    rail_t = m_t; rail_f = m_f; ack = 1'b1; dly = 0;
                end else begin
                    dly++;
                end
            end else if (!req && ack) begin
                ack = 1'b0;
                rail_t = m_bad ? 2'b01 : 2'b00;
                rail_f = 2'b00;
            end else begin
                dly = 0;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] t, input logic [1:0] f, input logic bad_sp,
                                input logic clr, input int ev, input logic [1:0] ec,
                                input logic ecode, input logic eseq);
        vec_t v;
        v.t = t; v.f = f; v.bad_sp = bad_sp; v.clr = clr;
        v.exp_valid = ev; v.exp_cnt = ec; v.exp_code = ecode; v.exp_seq = eseq;
        return v;
    endfunction

    // One full handshake with the model presenting v; checks after busy drops.
    task automatic do_vec(input vec_t v, input int idx);
        int n0;
        int k;
        m_t = v.t; m_f = v.f; m_bad = v.bad_sp;
        if (v.clr) begin
            clr_err = 1'b1; @(negedge clk); clr_err = 1'b0;
        end
        n0 = n_valid;
        k = 0;
        while (!busy && k < 100) begin @(negedge clk); k++; end
        chk($sformatf("v%0d_busy_rise", idx), int'(busy), 1);
        k = 0;
        while (busy && k < 200) begin @(negedge clk); k++; end
        chk($sformatf("v%0d_busy_fall", idx), int'(busy), 0);
        chk($sformatf("v%0d_valid_pulses", idx), n_valid - n0, v.exp_valid);
        chk($sformatf("v%0d_count", idx), int'(count_out), int'(v.exp_cnt));
        chk($sformatf("v%0d_code_err", idx), int'(code_err), int'(v.exp_code));
        chk($sformatf("v%0d_seq_err", idx), int'(seq_err), int'(v.exp_seq));
        chk($sformatf("v%0d_timeout_err", idx), int'(timeout_err), 0);
    endtask

    initial begin
        vec_t vecs[10];
        int   k;
        int   n0;

        vecs[0] = mk(2'd0, 2'd3, 1'b0, 1'b0, 1, 2'd0, 1'b0, 1'b0);
        vecs[1] = mk(2'd1, 2'd2, 1'b0, 1'b0, 1, 2'd1, 1'b0, 1'b0);
        vecs[2] = mk(2'd2, 2'd1, 1'b0, 1'b0, 1, 2'd2, 1'b0, 1'b0);
        vecs[3] = mk(2'd3, 2'd0, 1'b0, 1'b0, 1, 2'd3, 1'b0, 1'b0);
        vecs[4] = mk(2'd0, 2'd3, 1'b0, 1'b0, 1, 2'd0, 1'b0, 1'b0);  // wrap 3->0
        vecs[5] = mk(2'd1, 2'd1, 1'b0, 1'b0, 0, 2'd0, 1'b1, 1'b0);  // both rails of bit0 high
        vecs[6] = mk(2'd1, 2'd2, 1'b0, 1'b1, 1, 2'd1, 1'b0, 1'b0);
        vecs[7] = mk(2'd3, 2'd0, 1'b0, 1'b0, 1, 2'd3, 1'b0, 1'b1);  // skip 2
        vecs[8] = mk(2'd0, 2'd3, 1'b1, 1'b1, 1, 2'd0, 1'b1, 1'b0);  // dirty spacer
        vecs[9] = mk(2'd1, 2'd2, 1'b0, 1'b1, 1, 2'd1, 1'b0, 1'b0);

        rst_n = 1'b0; run = 1'b0; clr_err = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_req", int'(req), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count_out), 0);
        chk("rst_valid", int'(count_valid), 0);
        chk("rst_code", int'(code_err), 0);
        chk("rst_seq", int'(seq_err), 0);
        chk("rst_tmo", int'(timeout_err), 0);
        rst_n = 1'b1;
        @(negedge clk);

        run = 1'b1;
        for (int i = 0; i < 10; i++) do_vec(vecs[i], i);

        // Missing ack: timeout after TIMEOUT+1 REQ_HI cycles, then RTZ + GAP + IDLE.
        m_mute = 1'b1;
        k = 0;
        while (!req && k < 20) begin @(negedge clk); k++; end
        chk("tmo_req_rise", int'(req), 1);
        k = 0;
        while (!timeout_err && k < 40) begin @(negedge clk); k++; end
        chk("tmo_cycles", k, 9);
        chk("tmo_req_fall", int'(req), 0);
        k = 0;
        while (!req && k < 40) begin @(negedge clk); k++; end
        chk("tmo_gap_cycles", k, 7);
        chk("tmo_no_code", int'(code_err), 0);
        run = 1'b0;
        k = 0;
        while (busy && k < 60) begin @(negedge clk); k++; end
        chk("stop_idle", int'(busy), 0);
        k = 0;
        repeat (20) begin @(negedge clk); if (req) k++; end
        chk("stopped_req", k, 0);
        chk("tmo_sticky", int'(timeout_err), 1);

        // Reset while in SETTLE: no sample, everything back to reset values.
        m_mute = 1'b0; m_t = 2'd2; m_f = 2'd1; m_bad = 1'b0;
        run = 1'b1;
        k = 0;
        while (!ack && k < 40) begin @(posedge clk); k++; end
        chk("rst_mid_ack_seen", int'(ack), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        n0 = n_valid;
        @(negedge clk);
        chk("midrst_req", int'(req), 0);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_count", int'(count_out), 0);
        chk("midrst_valid", int'(count_valid), 0);
        chk("midrst_code", int'(code_err), 0);
        chk("midrst_seq", int'(seq_err), 0);
        chk("midrst_tmo", int'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("midrst_no_pulse", n_valid - n0, 0);
        do_vec(mk(2'd2, 2'd1, 1'b0, 1'b0, 1, 2'd2, 1'b0, 1'b0), 10);
        do_vec(mk(2'd3, 2'd0, 1'b0, 1'b0, 1, 2'd3, 1'b0, 1'b0), 11);
        run = 1'b0;
        repeat (5) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
